mdc_delay_commutator: RTL and testbench
=======================================

Name: mdc_delay_commutator

Overview:
- Radix-2 MDC inter-stage delay/commutator. Sits directly upstream of the combinational input commutator of the next butterfly stage and feeds it a dual-path stream.
- Delays the upper input path by DEPTH samples and swaps the two paths every DEPTH samples.
- Delays the post-swap lower path by DEPTH samples, so that both outputs carry the sample pairs (distance DEPTH apart) that the next butterfly needs.
- All storage advances only on accepted samples (in_valid). Idle cycles stall the block without corrupting alignment.

Parameters:
- WIDTH, 9, signed bit width of each real/imag component.
- DEPTH, 8, delay length in samples; power of two, at least 1 (32-pt FFT stages use 8, 4, 2, 1).
- LOG2_DEPTH, 3, log2(DEPTH); the counter is LOG2_DEPTH+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upper/lower input pair valid this cycle (sample accepted).
- up_in_re  in  WIDTH  upper path input, real, signed.
- up_in_im  in  WIDTH  upper path input, imag, signed.
- low_in_re  in  WIDTH  lower path input, real, signed.
- low_in_im  in  WIDTH  lower path input, imag, signed.
- out_valid  out  1  output pair valid (registered).
- up_out_re  out  WIDTH  upper output, real (registered).
- up_out_im  out  WIDTH  upper output, imag (registered).
- low_out_re  out  WIDTH  lower output, real (registered).
- low_out_im  out  WIDTH  lower output, imag (registered).
- sel_out  out  1  switch phase used for the pair currently on the outputs (registered); the downstream commutator uses it for mode/flag sequencing.

Behaviour:
- Reset (async, rst=1): all outputs 0, out_valid 0, sel_out 0, counter cnt 0, primed 0, both delay lines cleared to 0. Reset mid-stream discards all buffered data; the next accepted sample after release is index n=0.
- Let n be the accepted-sample index since reset. U[n] and L[n] are the complex upper and lower inputs.
- Upper delay: a[n] = U[n-DEPTH]. Implemented as a DEPTH-deep shift register of 2*WIDTH bits, advanced only when in_valid=1.
- Phase: sel = cnt[LOG2_DEPTH]. cnt increments by 1 per accepted sample and wraps modulo 2*DEPTH (2*DEPTH-1 -> 0). No other wrap logic.
- Switch:
  - sel=0: top = a[n], bot = L[n].
  - sel=1: top = L[n], bot = a[n].
- Lower output delay: bot passes through a second DEPTH-deep shift register, advanced only on in_valid. The lower output is b[n] = bot[n-DEPTH].
- Output register, loaded on any cycle with in_valid=1:
  - up_out <= top
  - low_out <= b[n]
  - sel_out <= sel
  - out_valid <= primed
- primed sets once DEPTH samples have been accepted (n >= DEPTH) and stays set until reset.
- Latency: 1 clock from accepting sample n to the registered output for index n. Total path delays are DEPTH samples (upper, switched) and up to 2*DEPTH samples (lower).
- in_valid=0: every register holds except out_valid, which drops to 0 the next cycle. Data outputs hold their last values.
- No back-pressure. The consumer must accept every out_valid cycle.
- Arithmetic: none. Data passes bit-exact with no sign extension or rounding.
- DEPTH=1: both delay lines degenerate to single registers, sel toggles every sample. Same equations apply.

Optional Feature:
- Macro: MDC_DELAY_COMMUTATOR_BYPASS_EN.
- Defined: adds input port bypass (1 bit), placed after in_valid.
  - While bypass=1 and in_valid=1: up_out <= up_in, low_out <= low_in, sel_out <= 0, out_valid <= 1.
  - While bypass=1, cnt, primed and both delay lines are frozen.
  - Deasserting bypass resumes the stream at the frozen index.
- Undefined: no bypass port, logic absent.

Test Plan:
- DEPTH=2. Stimulus: in_valid=1 continuously; U[n].re=n+1, L[n].re=101+n, im = -re.
  - out_valid stays 0 for the outputs of n=0,1.
  - Pairs (up.re, low.re) for n=2..7 = (103,101), (104,102), (3,1), (4,2), (107,105), (108,106).
  - sel_out = 1,1,0,0,1,1. Imaginary parts equal the negation of the real parts.
- Same stimulus with in_valid toggled 1,0,1,0,…: identical output sequence at the valid cycles; out_valid=0 and outputs held on the gap cycles.
- Async reset asserted mid-stream at n=5 (between clock edges): outputs and out_valid go to 0 immediately. After release, restarting the stream reproduces the first scenario exactly.
- DEPTH=1, U.re=n+1, L.re=101+n: outputs from n=1 are (102,101), (2,1), (104,103), (4,3), with sel_out 1,0,1,0.
- cnt wrap, DEPTH=8: run 40 accepted samples. sel_out changes exactly every 8 valid outputs, and the 17th accepted sample returns to sel=0.
- MDC_DELAY_COMMUTATOR_BYPASS_EN defined, DEPTH=2:
  - Assert bypass for 3 samples starting at n=4: outputs equal the inputs with 1-cycle latency and sel_out=0.
  - After bypass drops, the stream continues with index n=4 values (3,1).

Source files
------------

// File: rtl/mdc_delay_commutator_if.sv
// Dual-path complex stream bundle around the MDC delay/commutator: upper/lower input pair in, switched pair out.
// MDC_DELAY_COMMUTATOR_BYPASS_EN adds the bypass strobe next to in_valid.
interface mdc_delay_commutator_if #(
    parameter int WIDTH = 9
);
    logic                    in_valid;
`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
    logic                    bypass;
`endif
    logic signed [WIDTH-1:0] up_in_re;
    logic signed [WIDTH-1:0] up_in_im;
    logic signed [WIDTH-1:0] low_in_re;
    logic signed [WIDTH-1:0] low_in_im;
    logic                    out_valid;
    logic signed [WIDTH-1:0] up_out_re;
    logic signed [WIDTH-1:0] up_out_im;
    logic signed [WIDTH-1:0] low_out_re;
    logic signed [WIDTH-1:0] low_out_im;
    logic                    sel_out;

    modport master (
        output in_valid,
`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
        output bypass,
`endif
        output up_in_re, up_in_im, low_in_re, low_in_im,
        input  out_valid, up_out_re, up_out_im, low_out_re, low_out_im, sel_out
    );

    modport slave (
        input  in_valid,
`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
        input  bypass,
`endif
        input  up_in_re, up_in_im, low_in_re, low_in_im,
        output out_valid, up_out_re, up_out_im, low_out_re, low_out_im, sel_out
    );
endinterface

// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC inter-stage delay/commutator: delays upper path, swaps paths every DEPTH samples, re-delays lower path.
// Optional MDC_DELAY_COMMUTATOR_BYPASS_EN: bypass input passes the pair straight through and freezes the stream state.
module mdc_delay_commutator #(
    parameter int WIDTH      = 9,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mdc_delay_commutator_if.slave bus
);

    localparam int SW = 2 * WIDTH;
    localparam logic [LOG2_DEPTH:0] PRIME_CNT = (LOG2_DEPTH + 1)'(DEPTH - 1);

    logic [LOG2_DEPTH:0] r_cnt;
    logic                r_primed;
    logic [SW-1:0]       r_dly_up [DEPTH];
    logic [SW-1:0]       r_dly_lo [DEPTH];

    logic                w_byp_p0;
    logic                w_adv_p0;
    logic                w_sel_p0;
    logic [SW-1:0]       w_up_in_p0;
    logic [SW-1:0]       w_lo_in_p0;
    logic [SW-1:0]       w_a_p0;
    logic [SW-1:0]       w_b_p0;
    logic [SW-1:0]       w_top_p0;
    logic [SW-1:0]       w_bot_p0;

    logic                    r_vld_p1;
    logic                    r_sel_p1;
    logic signed [WIDTH-1:0] r_up_re_p1;
    logic signed [WIDTH-1:0] r_up_im_p1;
    logic signed [WIDTH-1:0] r_lo_re_p1;
    logic signed [WIDTH-1:0] r_lo_im_p1;

`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
    assign w_byp_p0 = bus.bypass;
`else
    assign w_byp_p0 = 1'b0;
`endif

    // Stream state only moves on accepted, non-bypassed samples so idle cycles never skew alignment
    assign w_adv_p0   = bus.in_valid & ~w_byp_p0;
    assign w_sel_p0   = r_cnt[LOG2_DEPTH];
    assign w_up_in_p0 = {bus.up_in_re, bus.up_in_im};
    assign w_lo_in_p0 = {bus.low_in_re, bus.low_in_im};
    assign w_a_p0     = r_dly_up[DEPTH-1];
    assign w_b_p0     = r_dly_lo[DEPTH-1];
    assign w_top_p0   = w_sel_p0 ? w_lo_in_p0 : w_a_p0;
    assign w_bot_p0   = w_sel_p0 ? w_a_p0     : w_lo_in_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dly_up[i] <= '0;
                r_dly_lo[i] <= '0;
            end
        end else if (w_adv_p0) begin
            r_dly_up[0] <= w_up_in_p0;
            r_dly_lo[0] <= w_bot_p0;
            for (int i = 1; i < DEPTH; i++) begin
                r_dly_up[i] <= r_dly_up[i-1];
                r_dly_lo[i] <= r_dly_lo[i-1];
            end
        end
    end

    // Counter wraps naturally at 2*DEPTH; primed latches once the upper delay line holds real data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (w_adv_p0) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == PRIME_CNT) begin
                r_primed <= 1'b1;
            end
        end
    end

    // ---- p0 -> p1: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_sel_p1   <= 1'b0;
            r_up_re_p1 <= '0;
            r_up_im_p1 <= '0;
            r_lo_re_p1 <= '0;
            r_lo_im_p1 <= '0;
        end else if (bus.in_valid) begin
            if (w_byp_p0) begin
                r_vld_p1   <= 1'b1;
                r_sel_p1   <= 1'b0;
                r_up_re_p1 <= bus.up_in_re;
                r_up_im_p1 <= bus.up_in_im;
                r_lo_re_p1 <= bus.low_in_re;
                r_lo_im_p1 <= bus.low_in_im;
            end else begin
                r_vld_p1   <= r_primed;
                r_sel_p1   <= w_sel_p0;
                r_up_re_p1 <= $signed(w_top_p0[SW-1:WIDTH]);
                r_up_im_p1 <= $signed(w_top_p0[WIDTH-1:0]);
                r_lo_re_p1 <= $signed(w_b_p0[SW-1:WIDTH]);
                r_lo_im_p1 <= $signed(w_b_p0[WIDTH-1:0]);
            end
        end else begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid  = r_vld_p1;
    assign bus.sel_out    = r_sel_p1;
    assign bus.up_out_re  = r_up_re_p1;
    assign bus.up_out_im  = r_up_im_p1;
    assign bus.low_out_re = r_lo_re_p1;
    assign bus.low_out_im = r_lo_im_p1;

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Scoreboard bench for mdc_delay_commutator: three instances (DEPTH 2, 1, 8) share one input stream,
// each compared against a sample-index reference model.
module tb_mdc_delay_commutator;

    localparam int W  = 9;
    localparam int ND = 3;

    typedef struct packed {
        logic signed [W-1:0] ure;
        logic signed [W-1:0] uim;
        logic signed [W-1:0] lre;
        logic signed [W-1:0] lim;
        logic                sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                s_valid;
    logic                s_byp;
    logic signed [W-1:0] s_ure, s_uim, s_lre, s_lim;
    logic                last_in_valid = 1'b0;

    logic [ND-1:0]        o_vld, o_sel;
    logic [ND-1:0][W-1:0] o_ure, o_uim, o_lre, o_lim;

    logic signed [W-1:0] hu_re [1024];
    logic signed [W-1:0] hu_im [1024];
    logic signed [W-1:0] hl_re [1024];
    logic signed [W-1:0] hl_im [1024];
    int                  n_acc = 0;

    exp_t       exp_q [ND][$];
    logic [2*W:0] log_q [ND][$];

    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) last_in_valid <= s_valid;

    function automatic int dep(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    endfunction

    // Reference model: expressed directly on the accepted-sample index n
    function automatic logic [2*W-1:0] up_at(input int k);
        if (k < 0) return '0;
        return {hu_re[k], hu_im[k]};
    endfunction

    function automatic logic [2*W-1:0] lo_at(input int k);
        return {hl_re[k], hl_im[k]};
    endfunction

    function automatic logic phase(input int d, input int k);
        return ((k / d) % 2) == 1;
    endfunction

    function automatic logic [2*W-1:0] bot_at(input int d, input int k);
        if (k < 0) return '0;
        return phase(d, k) ? up_at(k - d) : lo_at(k);
    endfunction

    function automatic exp_t model(input int d, input int n);
        logic [2*W-1:0] top;
        logic [2*W-1:0] low;
        top = phase(d, n) ? lo_at(n) : up_at(n - d);
        low = bot_at(d, n - d);
        return {top, low, phase(d, n)};
    endfunction

    function automatic logic signed [W-1:0] rnd();
        return W'($urandom);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int D  = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
        localparam int LG = (D == 8) ? 3 : ((D == 2) ? 1 : 0);

        mdc_delay_commutator_if #(.WIDTH(W)) bus ();

        assign bus.in_valid  = s_valid;
`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
        assign bus.bypass    = s_byp;
`endif
        assign bus.up_in_re  = s_ure;
        assign bus.up_in_im  = s_uim;
        assign bus.low_in_re = s_lre;
        assign bus.low_in_im = s_lim;

        mdc_delay_commutator #(.WIDTH(W), .DEPTH(D), .LOG2_DEPTH(LG)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign o_vld[g] = bus.out_valid;
        assign o_sel[g] = bus.sel_out;
        assign o_ure[g] = bus.up_out_re;
        assign o_uim[g] = bus.up_out_im;
        assign o_lre[g] = bus.low_out_re;
        assign o_lim[g] = bus.low_out_im;

        exp_t prev;
        bit   prev_ok = 1'b0;

        always @(negedge clk) begin : mon
            exp_t cur;
            exp_t e;
            cur = {o_ure[g], o_uim[g], o_lre[g], o_lim[g], o_sel[g]};
            if (rst) begin
                prev_ok = 1'b0;
            end else begin
                if (o_vld[g]) begin
                    n_checks++;
                    if (exp_q[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out D=%0d: out_valid=1 but no pair was required", D);
                    end else begin
                        e = exp_q[g].pop_front();
                        log_q[g].push_back({cur.sel, cur.ure, cur.lre});
                        if (cur !== e) begin
                            n_fail++;
                            $display("FAIL pair D=%0d: got up=(%0d,%0d) low=(%0d,%0d) sel=%0b, required up=(%0d,%0d) low=(%0d,%0d) sel=%0b",
                                     D, cur.ure, cur.uim, cur.lre, cur.lim, cur.sel,
                                     e.ure, e.uim, e.lre, e.lim, e.sel);
                        end
                    end
                end else if (prev_ok && !last_in_valid) begin
                    n_checks++;
                    if (cur !== prev) begin
                        n_fail++;
                        $display("FAIL hold D=%0d: got up=(%0d,%0d) low=(%0d,%0d) sel=%0b, required held up=(%0d,%0d) low=(%0d,%0d) sel=%0b",
                                 D, cur.ure, cur.uim, cur.lre, cur.lim, cur.sel,
                                 prev.ure, prev.uim, prev.lre, prev.lim, prev.sel);
                    end
                end
                prev    = cur;
                prev_ok = 1'b1;
            end
        end
    end

    task automatic drive(input bit v, input bit byp, input logic signed [W-1:0] ure, uim, lre, lim);
        @(posedge clk);
        #1;
        s_valid = v;
        s_byp   = byp;
        s_ure   = ure;
        s_uim   = uim;
        s_lre   = lre;
        s_lim   = lim;
        if (v) begin
            if (byp) begin
                for (int g = 0; g < ND; g++) exp_q[g].push_back({ure, uim, lre, lim, 1'b0});
            end else begin
                hu_re[n_acc] = ure;
                hu_im[n_acc] = uim;
                hl_re[n_acc] = lre;
                hl_im[n_acc] = lim;
                for (int g = 0; g < ND; g++) begin
                    if (n_acc >= dep(g)) exp_q[g].push_back(model(dep(g), n_acc));
                end
                n_acc++;
            end
        end
    endtask

    task automatic drive_tp(input int n);
        drive(1'b1, 1'b0, W'(n + 1), W'(-(n + 1)), W'(101 + n), W'(-(101 + n)));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic do_reset();
        #2;
        s_valid = 1'b0;
        s_byp   = 1'b0;
        rst     = 1'b1;
        #1;
        for (int g = 0; g < ND; g++) begin
            n_checks++;
            if ({o_vld[g], o_sel[g], o_ure[g], o_uim[g], o_lre[g], o_lim[g]} !== '0) begin
                n_fail++;
                $display("FAIL reset D=%0d: got vld=%0b sel=%0b up=(%0d,%0d) low=(%0d,%0d), required all 0",
                         dep(g), o_vld[g], o_sel[g], $signed(o_ure[g]), $signed(o_uim[g]),
                         $signed(o_lre[g]), $signed(o_lim[g]));
            end
            exp_q[g].delete();
            log_q[g].delete();
        end
        n_acc = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic check_log(input int g, input int idx, input int ure, input int lre, input bit sel, input string name);
        logic [2*W:0] want;
        logic [2*W:0] got;
        want = {sel, W'(ure), W'(lre)};
        n_checks++;
        if (idx >= log_q[g].size()) begin
            n_fail++;
            $display("FAIL %s D=%0d: output %0d missing (only %0d seen), required (%0d,%0d) sel=%0b",
                     name, dep(g), idx, log_q[g].size(), ure, lre, sel);
        end else begin
            got = log_q[g][idx];
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s D=%0d: output %0d got (%0d,%0d) sel=%0b, required (%0d,%0d) sel=%0b",
                         name, dep(g), idx, $signed(got[2*W-1:W]), $signed(got[W-1:0]), got[2*W],
                         ure, lre, sel);
            end
        end
    endtask

    task automatic check_tables(input string name);
        check_log(0, 0, 103, 101, 1'b1, name);
        check_log(0, 1, 104, 102, 1'b1, name);
        check_log(0, 2,   3,   1, 1'b0, name);
        check_log(0, 3,   4,   2, 1'b0, name);
        check_log(0, 4, 107, 105, 1'b1, name);
        check_log(0, 5, 108, 106, 1'b1, name);
        check_log(1, 0, 102, 101, 1'b1, name);
        check_log(1, 1,   2,   1, 1'b0, name);
        check_log(1, 2, 104, 103, 1'b1, name);
        check_log(1, 3,   4,   3, 1'b0, name);
    endtask

    initial begin
        logic [2*W:0] ent;
        s_valid = 1'b0;
        s_byp   = 1'b0;
        s_ure   = '0;
        s_uim   = '0;
        s_lre   = '0;
        s_lim   = '0;

        do_reset();

        // Continuous known-answer stream
        for (int n = 0; n < 8; n++) drive_tp(n);
        repeat (3) idle();
        check_tables("kat_cont");
        n_checks++;
        if (log_q[0].size() != 6) begin
            n_fail++;
            $display("FAIL vld_count D=2: got %0d valid outputs, required 6", log_q[0].size());
        end

        // Same stream with gaps between every sample
        do_reset();
        for (int n = 0; n < 8; n++) begin
            drive_tp(n);
            idle();
        end
        repeat (3) idle();
        check_tables("kat_gap");

        // Asynchronous reset mid-stream, then restart
        do_reset();
        for (int n = 0; n < 6; n++) drive_tp(n);
        do_reset();
        for (int n = 0; n < 8; n++) drive_tp(n);
        repeat (3) idle();
        check_tables("kat_restart");

        // 40 accepted samples: DEPTH=8 phase flips every 8 valid outputs
        do_reset();
        for (int n = 0; n < 40; n++) drive(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        repeat (3) idle();
        n_checks++;
        if (log_q[2].size() != 32) begin
            n_fail++;
            $display("FAIL wrap_count D=8: got %0d valid outputs, required 32", log_q[2].size());
        end
        for (int j = 0; j < 32; j++) begin
            if (j < log_q[2].size()) begin
                ent = log_q[2][j];
                n_checks++;
                if (ent[2*W] !== 1'(((j / 8) + 1) % 2)) begin
                    n_fail++;
                    $display("FAIL wrap_sel D=8: output %0d got sel=%0b, required %0b",
                             j, ent[2*W], 1'(((j / 8) + 1) % 2));
                end
            end
        end

        // Random data with random idle gaps
        for (int i = 0; i < 150; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'b0, rnd(), rnd(), rnd(), rnd());
        end
        repeat (3) idle();

`ifdef MDC_DELAY_COMMUTATOR_BYPASS_EN
        do_reset();
        for (int n = 0; n < 4; n++) drive_tp(n);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        for (int n = 4; n < 8; n++) drive_tp(n);
        repeat (3) idle();
        check_log(0, 5, 3, 1, 1'b0, "bypass_resume");
        check_log(0, 6, 4, 2, 1'b0, "bypass_resume");
        for (int i = 0; i < 20; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), rnd(), rnd(), rnd(), rnd());
        end
        repeat (3) idle();
`endif

        for (int g = 0; g < ND; g++) begin
            n_checks++;
            if (exp_q[g].size() != 0) begin
                n_fail++;
                $display("FAIL drain D=%0d: %0d required pairs never appeared, required 0", dep(g), exp_q[g].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
